// File: rtl/scpad_req_arbiter.sv
// Per-scratchpad request arbiter: merges FE and BE read/write requests into
// one registered read slot and one registered write slot. BE has priority,
// with a bounded FE starvation override on conflicting channels.
module scpad_req_arbiter #(
  parameter int XBAR_W       = 160,
  parameter int DATA_W       = 512,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              be_rd_valid,
  input  logic [XBAR_W-1:0] be_rd_xbar,
  input  logic              be_wr_valid,
  input  logic [XBAR_W-1:0] be_wr_xbar,
  input  logic [DATA_W-1:0] be_wr_data,
  input  logic              fe_rd_valid,
  input  logic [XBAR_W-1:0] fe_rd_xbar,
  input  logic              fe_wr_valid,
  input  logic [XBAR_W-1:0] fe_wr_xbar,
  input  logic [DATA_W-1:0] fe_wr_data,
  input  logic              r_stall,
  input  logic              w_stall,
  output logic              be_stall,
  output logic              fe_stall,
  output logic              rd_out_valid,
  output logic              rd_out_src,
  output logic [XBAR_W-1:0] rd_out_xbar,
  output logic              wr_out_valid,
  output logic              wr_out_src,
  output logic [XBAR_W-1:0] wr_out_xbar,
  output logic [DATA_W-1:0] wr_out_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic              rd_valid_q, rd_valid_d;
  logic              rd_src_q, rd_src_d;
  logic [XBAR_W-1:0] rd_xbar_q, rd_xbar_d;
  logic              wr_valid_q, wr_valid_d;
  logic              wr_src_q, wr_src_d;
  logic [XBAR_W-1:0] wr_xbar_q, wr_xbar_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic can_load_rd, can_load_wr;
  logic be_any, fe_any, elig_be, elig_fe, conflict, override;
  logic gnt_be, gnt_fe;

  // Eligibility, conflict detection and grant; a requester's rd+wr pair is all-or-nothing
  always_comb begin
    can_load_rd = !rd_valid_q || !r_stall;
    can_load_wr = !wr_valid_q || !w_stall;
    be_any      = be_rd_valid || be_wr_valid;
    fe_any      = fe_rd_valid || fe_wr_valid;
    elig_be     = be_any && (!be_rd_valid || can_load_rd) && (!be_wr_valid || can_load_wr);
    elig_fe     = fe_any && (!fe_rd_valid || can_load_rd) && (!fe_wr_valid || can_load_wr);
    conflict    = (be_rd_valid && fe_rd_valid) || (be_wr_valid && fe_wr_valid);
    override    = (starve_q == LIMIT);
    gnt_be      = 1'b0;
    gnt_fe      = 1'b0;
    if (!rst) begin
      if (override) begin
        gnt_fe = elig_fe;
        gnt_be = elig_be && !(gnt_fe && conflict);
      end else begin
        gnt_be = elig_be;
        gnt_fe = elig_fe && !(gnt_be && conflict);
      end
    end
    be_stall = rst || (be_any && !gnt_be);
    fe_stall = rst || (fe_any && !gnt_fe);
  end

  // Next-state for both slots and the FE starvation counter
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_src_d   = rd_src_q;
    rd_xbar_d  = rd_xbar_q;
    wr_valid_d = wr_valid_q;
    wr_src_d   = wr_src_q;
    wr_xbar_d  = wr_xbar_q;
    wr_data_d  = wr_data_q;
    starve_d   = starve_q;

    // grants never overlap on a channel, so at most one of these loads fires
    if (gnt_be && be_rd_valid) begin
      rd_valid_d = 1'b1;
      rd_src_d   = 1'b1;
      rd_xbar_d  = be_rd_xbar;
    end else if (gnt_fe && fe_rd_valid) begin
      rd_valid_d = 1'b1;
      rd_src_d   = 1'b0;
      rd_xbar_d  = fe_rd_xbar;
    end else if (can_load_rd) begin
      rd_valid_d = 1'b0;
    end

    if (gnt_be && be_wr_valid) begin
      wr_valid_d = 1'b1;
      wr_src_d   = 1'b1;
      wr_xbar_d  = be_wr_xbar;
      wr_data_d  = be_wr_data;
    end else if (gnt_fe && fe_wr_valid) begin
      wr_valid_d = 1'b1;
      wr_src_d   = 1'b0;
      wr_xbar_d  = fe_wr_xbar;
      wr_data_d  = fe_wr_data;
    end else if (can_load_wr) begin
      wr_valid_d = 1'b0;
    end

    // only a loss to BE on a shared channel counts as starvation
    if (!fe_any || gnt_fe) begin
      starve_d = '0;
    end else if (gnt_be && conflict && (starve_q != LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Slot and counter registers; reset drops any in-flight request
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_src_q   <= 1'b0;
      rd_xbar_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_src_q   <= 1'b0;
      wr_xbar_q  <= '0;
      wr_data_q  <= '0;
      starve_q   <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_src_q   <= rd_src_d;
      rd_xbar_q  <= rd_xbar_d;
      wr_valid_q <= wr_valid_d;
      wr_src_q   <= wr_src_d;
      wr_xbar_q  <= wr_xbar_d;
      wr_data_q  <= wr_data_d;
      starve_q   <= starve_d;
    end
  end

  assign rd_out_valid = rd_valid_q;
  assign rd_out_src   = rd_src_q;
  assign rd_out_xbar  = rd_xbar_q;
  assign wr_out_valid = wr_valid_q;
  assign wr_out_src   = wr_src_q;
  assign wr_out_xbar  = wr_xbar_q;
  assign wr_out_data  = wr_data_q;

endmodule

// File: tb/tb_scpad_req_arbiter.sv
// Scoreboard bench for scpad_req_arbiter: each directed cycle states the
// expected stalls and queues the slot contents expected after the edge.
module tb_scpad_req_arbiter;

  localparam int XBAR_W = 160;
  localparam int DATA_W = 512;

  typedef struct {
    bit                v;
    bit                src;
    logic [XBAR_W-1:0] x;
    logic [DATA_W-1:0] d;
  } slot_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              be_rd_valid, be_wr_valid, fe_rd_valid, fe_wr_valid;
  logic [XBAR_W-1:0] be_rd_xbar, be_wr_xbar, fe_rd_xbar, fe_wr_xbar;
  logic [DATA_W-1:0] be_wr_data, fe_wr_data;
  logic              r_stall, w_stall;
  logic              be_stall, fe_stall;
  logic              rd_out_valid, rd_out_src, wr_out_valid, wr_out_src;
  logic [XBAR_W-1:0] rd_out_xbar, wr_out_xbar;
  logic [DATA_W-1:0] wr_out_data;

  int n_cmp = 0;
  int n_err = 0;
  slot_t rd_q[$];
  slot_t wr_q[$];
  slot_t NONE;

  always #5 clk = ~clk;

  scpad_req_arbiter #(.XBAR_W(XBAR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .be_rd_valid(be_rd_valid), .be_rd_xbar(be_rd_xbar),
    .be_wr_valid(be_wr_valid), .be_wr_xbar(be_wr_xbar), .be_wr_data(be_wr_data),
    .fe_rd_valid(fe_rd_valid), .fe_rd_xbar(fe_rd_xbar),
    .fe_wr_valid(fe_wr_valid), .fe_wr_xbar(fe_wr_xbar), .fe_wr_data(fe_wr_data),
    .r_stall(r_stall), .w_stall(w_stall),
    .be_stall(be_stall), .fe_stall(fe_stall),
    .rd_out_valid(rd_out_valid), .rd_out_src(rd_out_src), .rd_out_xbar(rd_out_xbar),
    .wr_out_valid(wr_out_valid), .wr_out_src(wr_out_src), .wr_out_xbar(wr_out_xbar),
    .wr_out_data(wr_out_data)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic slot_t mk(input bit v, input bit src, input logic [XBAR_W-1:0] x,
                               input logic [DATA_W-1:0] d);
    slot_t s;
    s.v = v; s.src = src; s.x = x; s.d = d;
    return s;
  endfunction

  task automatic idle_inputs();
    be_rd_valid = 0; be_wr_valid = 0; fe_rd_valid = 0; fe_wr_valid = 0;
    be_rd_xbar = '0; be_wr_xbar = '0; fe_rd_xbar = '0; fe_wr_xbar = '0;
    be_wr_data = '0; fe_wr_data = '0;
  endtask

  // Inputs are already driven (just after a posedge). Check stalls, queue the
  // expected slots, cross the edge, then pop and compare the registered outputs.
  task automatic cyc(input string tag, input bit ebs, input bit efs, input slot_t erd, input slot_t ewr);
    slot_t r, w;
    #1;
    chk({tag, ".be_stall"}, be_stall, ebs);
    chk({tag, ".fe_stall"}, fe_stall, efs);
    rd_q.push_back(erd);
    wr_q.push_back(ewr);
    @(posedge clk);
    #1;
    r = rd_q.pop_front();
    w = wr_q.pop_front();
    chk({tag, ".rd_valid"}, rd_out_valid, r.v);
    if (r.v) begin
      chk({tag, ".rd_src"}, rd_out_src, r.src);
      chk({tag, ".rd_xbar"}, rd_out_xbar, r.x);
    end
    chk({tag, ".wr_valid"}, wr_out_valid, w.v);
    if (w.v) begin
      chk({tag, ".wr_src"}, wr_out_src, w.src);
      chk({tag, ".wr_xbar"}, wr_out_xbar, w.x);
      chk({tag, ".wr_data"}, wr_out_data, w.d);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] d5a;
    NONE = mk(0, 0, '0, '0);
    d5a = {64{8'h5A}};
    idle_inputs();
    r_stall = 0; w_stall = 0;
    rst = 1;
    @(posedge clk); #1;

    // T1 reset with every requester asserting
    be_rd_valid = 1; be_wr_valid = 1; fe_rd_valid = 1; fe_wr_valid = 1;
    for (int i = 0; i < 2; i++) cyc("t1_rst", 1, 1, NONE, NONE);
    rst = 0;
    idle_inputs();
    chk("t1_starve", dut.starve_q, 0);
    cyc("t1_idle", 0, 0, NONE, NONE);

    // T2 BE beats FE on a read conflict, FE follows once BE drops
    be_rd_valid = 1; be_rd_xbar = 'hA; fe_rd_valid = 1; fe_rd_xbar = 'hB;
    cyc("t2_be", 0, 1, mk(1, 1, 'hA, '0), NONE);
    be_rd_valid = 0;
    cyc("t2_fe", 0, 0, mk(1, 0, 'hB, '0), NONE);
    idle_inputs();
    cyc("t2_idle", 0, 0, NONE, NONE);

    // T3 starvation override after four consecutive FE losses
    be_rd_valid = 1; be_rd_xbar = 'hA; fe_rd_valid = 1; fe_rd_xbar = 'hB;
    for (int i = 0; i < 4; i++) cyc($sformatf("t3_loss%0d", i), 0, 1, mk(1, 1, 'hA, '0), NONE);
    cyc("t3_ovr", 1, 0, mk(1, 0, 'hB, '0), NONE);
    cyc("t3_resume", 0, 1, mk(1, 1, 'hA, '0), NONE);
    idle_inputs();
    cyc("t3_idle", 0, 0, NONE, NONE);

    // T4 read slot held under r_stall while the write slot keeps accepting FE
    be_rd_valid = 1; be_rd_xbar = 'hC1;
    cyc("t4_fill", 0, 0, mk(1, 1, 'hC1, '0), NONE);
    r_stall = 1; be_rd_xbar = 'hC2; fe_wr_valid = 1; fe_wr_xbar = 'hD1;
    for (int i = 0; i < 3; i++) begin
      fe_wr_data = DATA_W'(32'h7700 + i);
      cyc($sformatf("t4_stall%0d", i), 1, 0, mk(1, 1, 'hC1, '0),
          mk(1, 0, 'hD1, DATA_W'(32'h7700 + i)));
    end
    r_stall = 0; fe_wr_valid = 0;
    cyc("t4_release", 0, 0, mk(1, 1, 'hC2, '0), NONE);
    idle_inputs();
    cyc("t4_idle", 0, 0, NONE, NONE);

    // T5 disjoint channels granted together
    be_rd_valid = 1; be_rd_xbar = 'hE1; fe_wr_valid = 1; fe_wr_xbar = 'hE2; fe_wr_data = d5a;
    cyc("t5_both", 0, 0, mk(1, 1, 'hE1, '0), mk(1, 0, 'hE2, d5a));
    idle_inputs();
    cyc("t5_idle", 0, 0, NONE, NONE);

    // T6 FE rd+wr pair is atomic against a stalled write slot
    be_wr_valid = 1; be_wr_xbar = 'hF0; be_wr_data = 'h11;
    cyc("t6_fill", 0, 0, NONE, mk(1, 1, 'hF0, 'h11));
    idle_inputs();
    w_stall = 1;
    fe_rd_valid = 1; fe_rd_xbar = 'hF1; fe_wr_valid = 1; fe_wr_xbar = 'hF2; fe_wr_data = 'h22;
    for (int i = 0; i < 2; i++) cyc($sformatf("t6_block%0d", i), 0, 1, NONE, mk(1, 1, 'hF0, 'h11));
    w_stall = 0;
    cyc("t6_pair", 0, 0, mk(1, 0, 'hF1, '0), mk(1, 0, 'hF2, 'h22));
    r_stall = 1; w_stall = 1;
    cyc("t6_hold", 0, 1, mk(1, 0, 'hF1, '0), mk(1, 0, 'hF2, 'h22));
    rst = 1;
    cyc("t6_rst", 1, 1, NONE, NONE);
    rst = 0; r_stall = 0; w_stall = 0;
    idle_inputs();
    cyc("t6_idle", 0, 0, NONE, NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
